// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single player RAM port between the start-up
// initialiser, the transaction controller and the VGA money display.
// One owner at a time; reads are tagged with their owner so the result
// returned READ_LATENCY cycles later reaches only the issuing requester.
module ram_arbiter #(
  parameter int DATA_W       = 48,
  parameter int READ_LATENCY = 2,
  parameter int MAX_HOLD     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init_req,
  input  logic              init_wren,
  input  logic              init_access_type,
  input  logic [DATA_W-1:0] init_data,
  output logic              init_gnt,
  input  logic              txn_req,
  input  logic              txn_wren,
  input  logic              txn_access_type,
  input  logic [DATA_W-1:0] txn_data,
  output logic              txn_gnt,
  input  logic              disp_req,
  input  logic              disp_access_type,
  output logic              disp_gnt,
  output logic              ram_access_type,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_result,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        rd_owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    TXN  = 2'd2,
    DISP = 2'd3
  } state_t;

  localparam int unsigned RL = READ_LATENCY;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  localparam logic [1:0] OWN_INIT = 2'b00;
  localparam logic [1:0] OWN_TXN  = 2'b01;
  localparam logic [1:0] OWN_DISP = 2'b10;

  state_t        state, state_n;
  logic          rr_last, rr_last_n;   // 1 = display was last served
  logic [HW-1:0] hold_cnt;

  logic          own_req;
  logic          own_wren;
  logic [1:0]    own_code;
  logic          rd_issue;

  logic [RL-1:0] pipe_vld;
  logic [1:0]    pipe_own [RL];

  // Next-state arbitration: init absolute priority, txn/disp round-robin.
  always_comb begin
    state_n   = state;
    rr_last_n = rr_last;
    case (state)
      IDLE: begin
        if (init_req) begin
          state_n = INIT;
        end else if (txn_req && (!disp_req || rr_last)) begin
          state_n   = TXN;
          rr_last_n = 1'b0;
        end else if (disp_req) begin
          state_n   = DISP;
          rr_last_n = 1'b1;
        end
      end
      INIT: if (!init_req) state_n = IDLE;
      TXN:  if (!txn_req)  state_n = IDLE;
      DISP: if (!disp_req || (hold_cnt == HOLD_LAST && txn_req)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, round-robin pointer and display hold counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state   <= state_n;
      rr_last <= rr_last_n;
      if (state == DISP && state_n == DISP)
        hold_cnt <= (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
      else
        hold_cnt <= '0;
    end
  end

  assign init_gnt = (state == INIT);
  assign txn_gnt  = (state == TXN);
  assign disp_gnt = (state == DISP);

  // RAM port mux driven by the current owner; IDLE drives all zeros.
  always_comb begin
    own_req         = 1'b0;
    own_wren        = 1'b0;
    own_code        = OWN_INIT;
    ram_access_type = 1'b0;
    ram_data_in     = '0;
    case (state)
      INIT: begin
        own_req         = init_req;
        own_wren        = init_wren;
        own_code        = OWN_INIT;
        ram_access_type = init_access_type;
        ram_data_in     = init_data;
      end
      TXN: begin
        own_req         = txn_req;
        own_wren        = txn_wren;
        own_code        = OWN_TXN;
        ram_access_type = txn_access_type;
        ram_data_in     = txn_data;
      end
      DISP: begin
        own_req         = disp_req;
        own_wren        = 1'b0;
        own_code        = OWN_DISP;
        ram_access_type = disp_access_type;
        ram_data_in     = '0;
      end
      default: ;
    endcase
  end

  assign ram_wren = own_req & own_wren;
  assign rd_issue = own_req & ~own_wren;

  // Read-tag pipeline: each issued read emerges READ_LATENCY cycles later.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < RL; i++) pipe_own[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_issue;
      pipe_own[0] <= own_code;
      for (int unsigned i = 1; i < RL; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end
    end
  end

  assign rd_valid = pipe_vld[RL-1];
  assign rd_owner = pipe_own[RL-1];
  assign rd_data  = ram_result;
  assign busy     = (state != IDLE) | (|pipe_vld);

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed stimulus with a read scoreboard.
module tb_ram_arbiter;

  localparam int DW = 48;
  localparam int L  = 3;
  localparam int MH = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          init_req, init_wren, init_access_type;
  logic [DW-1:0] init_data;
  logic          init_gnt;
  logic          txn_req, txn_wren, txn_access_type;
  logic [DW-1:0] txn_data;
  logic          txn_gnt;
  logic          disp_req, disp_access_type;
  logic          disp_gnt;
  logic          ram_access_type, ram_wren;
  logic [DW-1:0] ram_data_in, ram_result, rd_data;
  logic          rd_valid;
  logic [1:0]    rd_owner;
  logic          busy;

  typedef struct {
    logic [1:0]    own;
    logic [DW-1:0] dat;
    int            due;
  } exp_t;

  exp_t q[$];
  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;

  ram_arbiter #(.DATA_W(DW), .READ_LATENCY(L), .MAX_HOLD(MH)) dut (
    .clock(clock), .reset(reset),
    .init_req(init_req), .init_wren(init_wren),
    .init_access_type(init_access_type), .init_data(init_data), .init_gnt(init_gnt),
    .txn_req(txn_req), .txn_wren(txn_wren),
    .txn_access_type(txn_access_type), .txn_data(txn_data), .txn_gnt(txn_gnt),
    .disp_req(disp_req), .disp_access_type(disp_access_type), .disp_gnt(disp_gnt),
    .ram_access_type(ram_access_type), .ram_wren(ram_wren), .ram_data_in(ram_data_in),
    .ram_result(ram_result), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_owner(rd_owner), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Two-word RAM with L-cycle read latency.
  logic [DW-1:0] mem [2];
  logic [DW-1:0] rdq [L];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_access_type] <= ram_data_in;
    rdq[0] <= mem[ram_access_type];
    for (int i = 1; i < L; i++) rdq[i] <= rdq[i-1];
  end
  assign ram_result = rdq[L-1];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_gnt(input string name, input logic [2:0] exp);
    chk(name, {61'd0, init_gnt, txn_gnt, disp_gnt}, {61'd0, exp});
  endtask

  task automatic exp_read(input logic [1:0] own, input logic [DW-1:0] dat);
    exp_t e;
    e.own = own;
    e.dat = dat;
    e.due = cyc + L;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    init_req = 0; init_wren = 0; init_access_type = 0; init_data = '0;
    txn_req = 0; txn_wren = 0; txn_access_type = 0; txn_data = '0;
    disp_req = 0; disp_access_type = 0;

    // Scoreboard monitor: compares every rd_valid against the queue head.
    fork
      begin
        exp_t e;
        forever begin
          @(negedge clock);
          if (rd_valid) begin
            asserts++;
            if (q.size() == 0) begin
              fails++;
              $display("FAIL rd_unexpected: actual owner %0d data 0x%0h required no read (cycle %0d)",
                       rd_owner, rd_data, cyc);
            end else begin
              e = q.pop_front();
              if (rd_owner !== e.own || rd_data !== e.dat || cyc != e.due) begin
                fails++;
                $display("FAIL rd_check: actual owner %0d data 0x%0h cycle %0d required owner %0d data 0x%0h cycle %0d",
                         rd_owner, rd_data, cyc, e.own, e.dat, e.due);
              end
            end
          end else if (q.size() > 0 && q[0].due <= cyc) begin
            asserts++;
            fails++;
            e = q.pop_front();
            $display("FAIL rd_missing: actual no rd_valid at cycle %0d required owner %0d data 0x%0h",
                     cyc, e.own, e.dat);
          end
        end
      end
    join_none

    // Reset values
    step(); step();
    init_data = 48'h1234; txn_data = 48'h5678;
    #1;
    chk_gnt("reset_gnt", 3'b000);
    chk("reset_ram", {62'd0, ram_wren, ram_access_type}, 64'd0);
    chk("reset_ram_data", {16'd0, ram_data_in}, 64'd0);
    chk("reset_rd", {61'd0, rd_valid, rd_owner}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;

    // Initialiser writes 0x64 to player 1
    init_req = 1; init_wren = 1; init_access_type = 1; init_data = 48'h64;
    step(); #1;
    chk_gnt("init_gnt", 3'b100);
    chk("init_wr_ctl", {62'd0, ram_wren, ram_access_type}, 64'd3);
    chk("init_wr_data", {16'd0, ram_data_in}, 64'h64);
    step();
    init_req = 0; #1;
    chk_gnt("init_release_gnt", 3'b100);
    chk("init_release_wren", {63'd0, ram_wren}, 64'd0);
    step();
    chk_gnt("init_idle", 3'b000);
    chk("init_idle_busy", {63'd0, busy}, 64'd0);

    // Display reads player 1
    disp_req = 1; disp_access_type = 1;
    step();
    chk_gnt("disp_gnt", 3'b001);
    exp_read(2'b10, 48'h64);
    step();
    disp_req = 0;
    chk_gnt("disp_release", 3'b001);
    step();
    chk_gnt("disp_idle", 3'b000);
    chk("busy_read_in_flight", {63'd0, busy}, 64'd1);

    // Round-robin between txn (writing player 0) and display
    txn_wren = 1; txn_access_type = 0; txn_data = 48'hABC;
    for (int r = 0; r < 2; r++) begin
      txn_req = 1; disp_req = 1;
      for (int c = 0; c < 3; c++) begin
        step();
        chk_gnt("rr_txn", 3'b010);
      end
      step();
      txn_req = 0; #1;
      chk_gnt("rr_txn_release", 3'b010);
      chk("rr_txn_release_wren", {63'd0, ram_wren}, 64'd0);
      step();
      chk_gnt("rr_bubble_a", 3'b000);
      for (int c = 0; c < 3; c++) begin
        step();
        chk_gnt("rr_disp", 3'b001);
        exp_read(2'b10, 48'h64);
      end
      step();
      disp_req = 0;
      chk_gnt("rr_disp_release", 3'b001);
      step();
      chk_gnt("rr_bubble_b", 3'b000);
    end

    // Display preempted after MAX_HOLD cycles by a pending txn request
    disp_req = 1;
    for (int d = 1; d <= MH; d++) begin
      step();
      if (d == 3) txn_req = 1;
      chk_gnt("hold_disp", 3'b001);
      exp_read(2'b10, 48'h64);
    end
    step();
    chk_gnt("preempt_idle", 3'b000);
    step();
    chk_gnt("preempt_txn", 3'b010);
    txn_req = 0; disp_req = 0; #1;
    chk("first_cycle_drop_wren", {63'd0, ram_wren}, 64'd0);
    step();
    chk_gnt("preempt_done", 3'b000);

    // Txn read returns while the display owns the RAM
    txn_wren = 0; txn_access_type = 0; txn_req = 1;
    step();
    chk_gnt("txn_read_gnt", 3'b010);
    exp_read(2'b01, 48'hABC);
    disp_req = 1;
    step();
    txn_req = 0;
    chk_gnt("txn_read_release", 3'b010);
    step();
    chk_gnt("txn_read_bubble", 3'b000);
    step();
    chk_gnt("disp_after_txn", 3'b001);
    chk("txn_rd_while_disp", {61'd0, rd_valid, rd_owner}, 64'd5);
    exp_read(2'b10, 48'h64);
    step();
    disp_req = 0;
    chk_gnt("disp_after_txn_release", 3'b001);
    step();
    chk_gnt("txn_disp_done", 3'b000);

    // Reset with txn reads in flight
    txn_req = 1;
    step();
    chk_gnt("rst_txn_gnt", 3'b010);
    step();
    chk("rst_busy_before", {63'd0, busy}, 64'd1);
    step();
    reset = 1;
    step();
    reset = 0; txn_req = 0; #1;
    chk_gnt("rst_gnt", 3'b000);
    chk("rst_wren", {63'd0, ram_wren}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    for (int c = 0; c < L; c++) begin
      step();
      chk("rst_flushed", {63'd0, rd_valid}, 64'd0);
    end

    // All three request at once: init first, then txn (rr_last reset)
    init_wren = 0; init_access_type = 1; disp_access_type = 1;
    init_req = 1; txn_req = 1; disp_req = 1;
    step();
    chk_gnt("all3_init", 3'b100);
    exp_read(2'b00, 48'h64);
    step();
    init_req = 0;
    chk_gnt("all3_init_release", 3'b100);
    step();
    chk_gnt("all3_bubble", 3'b000);
    step();
    chk_gnt("all3_txn", 3'b010);
    exp_read(2'b01, 48'hABC);
    step();
    txn_req = 0; disp_req = 0;
    chk_gnt("all3_txn_release", 3'b010);
    step();
    chk_gnt("all3_done", 3'b000);

    repeat (L + 2) step();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    chk("final_busy", {63'd0, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single 48-bit player RAM port between three requesters: the start-up memory initialiser, the transaction memory controller and the VGA money display reader. It grants one owner at a time and multiplexes that owner's access_type, wren and data_in onto the RAM. It tags every read with its owner so the returned ram_result reaches only the requester that issued it. It sits between the controllers/visuals and the RAM instance, replacing direct wiring of memory_control to the RAM.

## Interface
- DATA_W, 48, RAM word width
- READ_LATENCY, 2, cycles from read-issue cycle to valid ram_result (legal 1..4)
- MAX_HOLD, 16, maximum consecutive display-grant cycles while txn_req is pending

- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; one clock, reset synchronous active-high
- init_req  in  1  initialiser requests the RAM
- init_wren  in  1  initialiser write enable
- init_access_type  in  1  initialiser RAM address (player select)
- init_data  in  DATA_W  initialiser write data
- init_gnt  out  1  initialiser owns the RAM
- txn_req / txn_wren / txn_access_type / txn_data / txn_gnt  same as init_*, for the transaction controller
- disp_req  in  1  display requests the RAM (read-only)
- disp_access_type  in  1  display read address
- disp_gnt  out  1  display owns the RAM
- ram_access_type  out  1  to RAM
- ram_wren  out  1  to RAM
- ram_data_in  out  DATA_W  to RAM
- ram_result  in  DATA_W  from RAM
- rd_data  out  DATA_W  = ram_result, qualified by rd_valid
- rd_valid  out  1  rd_data is a completed read
- rd_owner  out  2  00 init, 01 txn, 10 disp; meaningful only with rd_valid
- busy  out  1  a grant is active or a read is in flight

## Operation
- FSM states: IDLE, INIT, TXN, DISP. Grants are registered: init_gnt = (state==INIT), and likewise for the others. At most one grant is high.
- IDLE arbitration, evaluated each cycle:
  - init_req wins absolutely.
  - Otherwise txn_req and disp_req use round-robin. rr_last (1 bit) records the last served of txn/disp; on a tie the other one wins. rr_last resets to "disp", so txn wins the first tie.
- Owner state is held while the owner's req = 1. When req = 0 is sampled, the FSM returns to IDLE. Every release costs one IDLE bubble, with no back-to-back grants.
- Preemption: hold_cnt counts consecutive DISP cycles. If hold_cnt reaches MAX_HOLD-1 and txn_req = 1, DISP goes to IDLE regardless of disp_req. The display must re-request. INIT and TXN are never preempted.
- RAM muxing (combinational from state):
  - ram_access_type = owner's access_type.
  - ram_data_in = owner's data.
  - ram_wren = owner's wren & owner's req & grant.
  - Display wren is constant 0.
  - In IDLE: ram_wren = 0, ram_access_type = 0, ram_data_in = 0.
- Read tracking: each granted cycle with owner req = 1 and ram_wren = 0 is a read issue. It pushes {1, owner} into a READ_LATENCY-deep shift register. rd_valid and rd_owner come from the last stage. rd_data = ram_result.
- busy = (state != IDLE) | any shift-register valid bit.

## Timing
- Reset values: all grants 0, state IDLE, ram_wren 0, ram_access_type 0, ram_data_in 0, rd_valid 0, rd_owner 00, busy 0, hold_cnt 0, rr_last = disp.
- Reset mid-operation: the read pipeline is flushed. No rd_valid fires for reads issued before reset.
- Grant latency: req sampled high in IDLE at edge n gives gnt high in cycle n+1.
- Release latency: req sampled low at edge m gives gnt low in cycle m+1. The earliest new grant is cycle m+2.
- Read: issued in cycle k gives rd_valid = 1 in cycle k+READ_LATENCY only, with rd_owner = issuer. This holds even if the grant has since moved to another owner.
- Write: takes effect at the edge ending the granted cycle with ram_wren = 1.
- Simultaneous init_req, txn_req and disp_req in IDLE: INIT is granted, and rr_last is unchanged.
- Owner drops req in its first granted cycle: gnt stays high that one cycle, ram_wren = 0, and no read is logged.
- hold_cnt clears on leaving DISP.

## Test plan
- Reset, then init_req = 1 with wren = 1, access_type = 1, data = 0x0000_0000_0064 for one cycle, then released. Expect: init_gnt one cycle later, a single write with ram_wren = 1, then IDLE. A display read of player 1 then returns rd_valid with rd_owner = 10 and rd_data = 0x64 exactly READ_LATENCY cycles after issue.
- txn_req and disp_req rise together, each holding 3 cycles, repeated twice. Expect grant order txn, disp, txn, disp, with one IDLE bubble between each.
- disp_req held continuously and txn_req raised at DISP cycle 3, MAX_HOLD = 16. Expect disp_gnt to fall after 16 DISP cycles and txn_gnt to rise 2 cycles later.
- TXN issues a read, then releases, and DISP is granted. Expect rd_valid with rd_owner = 01 after READ_LATENCY cycles, while disp_gnt = 1.
- reset asserted while TXN owns the RAM with 2 reads in flight. Expect: next cycle all grants 0 and ram_wren 0; no rd_valid for those reads; busy 0.
- All three requests asserted in the same cycle. Expect init_gnt first; after init releases, txn is granted (rr_last reset value).
